// File: rtl/sfx_pkg.sv
// ---------------------------------------------------------------------------
// sfx_pkg
// Shared definitions for the sound-effect voice generator:
//   - sfx_state_t  : effect state encoding (IDLE / SHOT / BOOM)
//   - LFSR_SEED    : seed reloaded into the noise LFSR on every explosion
//   - LFSR_TAPS    : feedback tap mask for taps 16/14/13/11 (bits 15/13/12/10)
//   - SILENCE      : PCM value written while no effect is playing
//   - signedSample : turns a sign bit plus envelope magnitude into a PCM word
// ---------------------------------------------------------------------------
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOT = 2'd1,
        BOOM = 2'd2
    } sfx_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] SILENCE   = 16'h0000;

    // The envelope never exceeds 32767, so ~mag + 1 cannot overflow into a
    // wrong sign; a zero envelope yields zero for either sign.
    function automatic logic [15:0] signedSample(input logic positive,
                                                 input logic [15:0] mag);
        return positive ? mag : (~mag + 16'd1);
    endfunction

endpackage

// File: rtl/sfx_lfsr.sv
// ---------------------------------------------------------------------------
// sfx_lfsr
// 16-bit Fibonacci LFSR (taps 16/14/13/11) used as the noise source of the
// explosion effect. Shifts towards the MSB; the new LSB is the XOR of the
// tapped bits. Only built when SFX_BOOM_EN is defined.
// Ports:
//   clk50     in   system clock
//   reset     in   asynchronous active-high reset (reloads the seed)
//   i_advance in   step the register once
//   i_load    in   reload the seed (wins over i_advance)
//   o_next    out  value the register takes on the next advance
// ---------------------------------------------------------------------------
module sfx_lfsr
    import sfx_pkg::*;
(
    input  logic        clk50,
    input  logic        reset,
    input  logic        i_advance,
    input  logic        i_load,
    output logic [15:0] o_next
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    // Feedback is the parity of the tapped bits of the current state.
    assign w_feedback = ^(r_lfsr & LFSR_TAPS);
    assign o_next     = {r_lfsr[14:0], w_feedback};

    // Seed on reset and on load; otherwise step only when asked, so the
    // noise sequence stays locked to accepted FIFO writes.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_load) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_advance) begin
            r_lfsr <= o_next;
        end
    end

endmodule

// File: rtl/sfx_voice_gen.sv
// ---------------------------------------------------------------------------
// sfx_voice_gen
// Turns single-cycle game events into a stream of signed 16-bit PCM samples
// for the audio FIFO. The FIFO full flag paces production, so one sample is
// consumed per DAC frame; when idle the block keeps writing silence.
//   SHOT : swept square wave with a linearly decaying envelope
//   BOOM : LFSR noise with a linearly decaying envelope
// Configuration macro: SFX_BOOM_EN -- when defined the BOOM state and the
// LFSR are built; otherwise boom_trig is ignored.
// Ports:
//   clk50       in   50 MHz system clock
//   reset       in   asynchronous active-high reset
//   shot_trig   in   one-cycle pulse, start/restart the shot effect
//   boom_trig   in   one-cycle pulse, start/restart the explosion effect
//   fifo_full   in   audio FIFO full flag
//   fifo_wr_req out  FIFO write strobe (= ~fifo_full)
//   fifo_wr_dat out  registered PCM sample presented to the FIFO
//   busy        out  high while an effect is playing
// ---------------------------------------------------------------------------
module sfx_voice_gen
    import sfx_pkg::*;
#(
    parameter logic [15:0] AMP        = 16'd12288,
    parameter logic [15:0] SHOT_LEN   = 16'd1600,
    parameter logic [15:0] SHOT_DECAY = 16'd7,
    parameter logic [15:0] SHOT_P0    = 16'd4,
    parameter logic [15:0] SHOT_SWEEP = 16'd64,
    parameter logic [15:0] BOOM_LEN   = 16'd4000,
    parameter logic [15:0] BOOM_DECAY = 16'd3
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        shot_trig,
    input  logic        boom_trig,
    input  logic        fifo_full,
    output logic        fifo_wr_req,
    output logic [15:0] fifo_wr_dat,
    output logic        busy
);

    sfx_state_t  r_state;
    sfx_state_t  w_stateNext;

    logic [15:0] r_sampleCnt, w_sampleCntNext;
    logic [15:0] r_env,       w_envNext;
    logic        r_phase,     w_phaseNext;
    logic [15:0] r_segCnt,    w_segCntNext;
    logic [15:0] r_segLen,    w_segLenNext;
    logic [15:0] r_halfPer,   w_halfPerNext;
    logic [15:0] r_sweepCnt,  w_sweepCntNext;
    logic [15:0] r_dat,       w_datNext;

    logic        w_write;
    logic        w_shotStart;
    logic        w_sweepWrap;
    logic [15:0] w_decay;
    logic [15:0] w_envDec;

`ifdef SFX_BOOM_EN
    logic        w_lfsrLoad;
    logic        w_lfsrAdvance;
    logic [15:0] w_lfsrNext;

    sfx_lfsr u_lfsr (
        .clk50     (clk50),
        .reset     (reset),
        .i_advance (w_lfsrAdvance),
        .i_load    (w_lfsrLoad),
        .o_next    (w_lfsrNext)
    );

    assign w_decay = (r_state == BOOM) ? BOOM_DECAY : SHOT_DECAY;
`else
    logic w_unusedBoom;

    assign w_unusedBoom = ^{boom_trig, BOOM_LEN, BOOM_DECAY};
    assign w_decay      = SHOT_DECAY;
`endif

    // The write strobe is purely combinational so a freshly deasserted full
    // flag is used in the same cycle; every strobed cycle is a write.
    assign fifo_wr_req = ~fifo_full;
    assign w_write     = ~fifo_full;
    assign fifo_wr_dat = r_dat;
    assign busy        = (r_state != IDLE);

    // A shot cannot interrupt an explosion; a boom in the same cycle wins
    // through the ordering of the next-state logic below.
    assign w_shotStart = shot_trig && (r_state != BOOM);

    // Envelope step, saturating at zero.
    assign w_envDec    = (r_env > w_decay) ? (r_env - w_decay) : 16'd0;

    // The sweep counter marks every SHOT_SWEEP-th sample, where the square
    // wave half-period grows by one.
    assign w_sweepWrap = (r_sweepCnt == (SHOT_SWEEP - 16'd1));

    // Next-state and next-sample logic. Triggers are honoured even while the
    // FIFO is full so a one-cycle event pulse is never lost; otherwise all
    // state advances only on a write. A half-period's length is fixed when
    // it starts, using the half-period in force for its first sample.
    always_comb begin
        w_stateNext     = r_state;
        w_sampleCntNext = r_sampleCnt;
        w_envNext       = r_env;
        w_phaseNext     = r_phase;
        w_segCntNext    = r_segCnt;
        w_segLenNext    = r_segLen;
        w_halfPerNext   = r_halfPer;
        w_sweepCntNext  = r_sweepCnt;
        w_datNext       = r_dat;
`ifdef SFX_BOOM_EN
        w_lfsrLoad      = 1'b0;
        w_lfsrAdvance   = 1'b0;

        if (boom_trig) begin
            w_stateNext     = BOOM;
            w_sampleCntNext = 16'd0;
            w_envNext       = AMP;
            w_lfsrLoad      = 1'b1;
            w_datNext       = signedSample(LFSR_SEED[15], AMP);
        end else
`endif
        if (w_shotStart) begin
            w_stateNext     = SHOT;
            w_sampleCntNext = 16'd0;
            w_envNext       = AMP;
            w_phaseNext     = 1'b1;
            w_segCntNext    = 16'd0;
            w_segLenNext    = SHOT_P0;
            w_halfPerNext   = SHOT_P0;
            w_sweepCntNext  = 16'd0;
            w_datNext       = signedSample(1'b1, AMP);
        end else if (w_write) begin
            case (r_state)
                SHOT: begin
                    if (r_sampleCnt == (SHOT_LEN - 16'd1)) begin
                        w_stateNext     = IDLE;
                        w_sampleCntNext = 16'd0;
                        w_envNext       = 16'd0;
                        w_datNext       = SILENCE;
                    end else begin
                        w_sampleCntNext = r_sampleCnt + 16'd1;
                        w_envNext       = w_envDec;
                        w_sweepCntNext  = w_sweepWrap ? 16'd0 : (r_sweepCnt + 16'd1);
                        w_halfPerNext   = r_halfPer + {15'd0, w_sweepWrap};
                        if ((r_segCnt + 16'd1) >= r_segLen) begin
                            w_phaseNext  = ~r_phase;
                            w_segCntNext = 16'd0;
                            w_segLenNext = w_halfPerNext;
                        end else begin
                            w_segCntNext = r_segCnt + 16'd1;
                        end
                        w_datNext = signedSample(w_phaseNext, w_envDec);
                    end
                end
`ifdef SFX_BOOM_EN
                BOOM: begin
                    if (r_sampleCnt == (BOOM_LEN - 16'd1)) begin
                        w_stateNext     = IDLE;
                        w_sampleCntNext = 16'd0;
                        w_envNext       = 16'd0;
                        w_datNext       = SILENCE;
                    end else begin
                        w_sampleCntNext = r_sampleCnt + 16'd1;
                        w_envNext       = w_envDec;
                        w_lfsrAdvance   = 1'b1;
                        w_datNext       = signedSample(w_lfsrNext[15], w_envDec);
                    end
                end
`endif
                default: begin
                    w_stateNext = IDLE;
                    w_datNext   = SILENCE;
                end
            endcase
        end
    end

    // State register: reset drops straight back to silence.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath registers: counters, envelope, square-wave bookkeeping and
    // the presented sample.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_sampleCnt <= 16'd0;
            r_env       <= 16'd0;
            r_phase     <= 1'b1;
            r_segCnt    <= 16'd0;
            r_segLen    <= SHOT_P0;
            r_halfPer   <= SHOT_P0;
            r_sweepCnt  <= 16'd0;
            r_dat       <= SILENCE;
        end else begin
            r_sampleCnt <= w_sampleCntNext;
            r_env       <= w_envNext;
            r_phase     <= w_phaseNext;
            r_segCnt    <= w_segCntNext;
            r_segLen    <= w_segLenNext;
            r_halfPer   <= w_halfPerNext;
            r_sweepCnt  <= w_sweepCntNext;
            r_dat       <= w_datNext;
        end
    end

endmodule

// File: tb/tb_sfx_voice_gen.sv
// ---------------------------------------------------------------------------
// tb_sfx_voice_gen
// Self-checking bench for sfx_voice_gen. A reference model tracks which
// effect is playing and the index of the presented sample; the expected PCM
// value is computed directly from the effect rules (envelope = AMP - k*DECAY,
// square-wave phase from a precomputed segment table, noise sign from a
// precomputed LFSR sequence). Honors SFX_BOOM_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sfx_voice_gen;

    localparam int AMP        = 12288;
    localparam int SHOT_LEN   = 1600;
    localparam int SHOT_DECAY = 7;
    localparam int SHOT_P0    = 4;
    localparam int SHOT_SWEEP = 64;
    localparam int BOOM_LEN   = 4000;
    localparam int BOOM_DECAY = 3;
`ifdef SFX_BOOM_EN
    localparam bit BOOM_EN = 1'b1;
`else
    localparam bit BOOM_EN = 1'b0;
`endif

    logic        clk50 = 1'b0;
    logic        reset = 1'b0;
    logic        shot_trig = 1'b0;
    logic        boom_trig = 1'b0;
    logic        fifo_full = 1'b1;
    logic        fifo_wr_req;
    logic [15:0] fifo_wr_dat;
    logic        busy;

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkOn     = 1'b0;

    // Model state: 0 = silence, 1 = shot, 2 = boom; idx = presented sample.
    int mEff = 0;
    int mIdx = 0;

    logic        shotPh  [0:SHOT_LEN-1];
    logic [15:0] boomSeq [0:BOOM_LEN-1];

    sfx_voice_gen dut (
        .clk50       (clk50),
        .reset       (reset),
        .shot_trig   (shot_trig),
        .boom_trig   (boom_trig),
        .fifo_full   (fifo_full),
        .fifo_wr_req (fifo_wr_req),
        .fifo_wr_dat (fifo_wr_dat),
        .busy        (busy)
    );

    // 50 MHz system clock.
    always #10 clk50 = ~clk50;

    // Expected PCM word for sample idx of the given effect.
    function automatic logic [15:0] expSample(input int eff, input int idx);
        int   env;
        logic pos;
        if (eff == 0) return 16'h0000;
        env = AMP - idx * ((eff == 1) ? SHOT_DECAY : BOOM_DECAY);
        if (env < 0) env = 0;
        pos = (eff == 1) ? shotPh[idx] : boomSeq[idx][15];
        return pos ? 16'(env) : 16'(-env);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let a rising edge happen, then return just
    // after the edge so outputs can be inspected.
    task automatic applyStimulus(input logic s, input logic b, input logic f, input logic r);
        shot_trig = s;
        boom_trig = b;
        fifo_full = f;
        reset     = r;
        @(posedge clk50);
        #2;
    endtask

    // Reference model: advances on each rising edge from the inputs that
    // were held across it; reset clears it immediately.
    always @(posedge clk50 or posedge reset) begin
        if (reset) begin
            mEff = 0;
            mIdx = 0;
        end else if (boom_trig && BOOM_EN) begin
            mEff = 2;
            mIdx = 0;
        end else if (shot_trig && mEff != 2) begin
            mEff = 1;
            mIdx = 0;
        end else if (!fifo_full && mEff != 0) begin
            mIdx++;
            if (mIdx == ((mEff == 1) ? SHOT_LEN : BOOM_LEN)) begin
                mEff = 0;
                mIdx = 0;
            end
        end
    end

    // Compare process: on every falling edge all three outputs are checked.
    always @(negedge clk50) begin
        if (checkOn) begin
            checkOutput("wr_req", {15'd0, fifo_wr_req}, {15'd0, ~fifo_full});
            checkOutput("wr_dat", fifo_wr_dat, expSample(mEff, mIdx));
            checkOutput("busy", {15'd0, busy}, {15'd0, (mEff != 0)});
        end
    end

    initial begin
        int pos;
        int len;
        logic ph;
        logic [15:0] l;

        // Square-wave phase table: a half-period beginning at sample s lasts
        // SHOT_P0 + s/SHOT_SWEEP samples; the first one is positive.
        pos = 0;
        ph  = 1'b1;
        while (pos < SHOT_LEN) begin
            len = SHOT_P0 + pos / SHOT_SWEEP;
            for (int j = 0; j < len && pos + j < SHOT_LEN; j++) shotPh[pos + j] = ph;
            pos += len;
            ph = ~ph;
        end
        // Noise sequence: state k is the seed stepped k times.
        l = 16'hACE1;
        for (int i = 0; i < BOOM_LEN; i++) begin
            boomSeq[i] = l;
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end

        // Hand-computed anchors for the model itself.
        checkOutput("pin_shot0",  expSample(1, 0),  16'd12288);
        checkOutput("pin_shot4",  expSample(1, 4),  16'hD01C);
        checkOutput("pin_shot63", expSample(1, 63), 16'hD1B9);
        checkOutput("pin_shot64", expSample(1, 64), 16'd11840);
        checkOutput("pin_shot69", expSample(1, 69), 16'hD1E3);
        checkOutput("pin_boom0",  expSample(2, 0),  16'd12288);
        checkOutput("pin_boom1",  expSample(2, 1),  16'hD003);

        // Reset with the FIFO full: no strobe, silent data.
        #1 reset = 1'b1;
        #2 checkOn = 1'b1;
        @(posedge clk50);
        #2;
        checkOutput("rst_req", {15'd0, fifo_wr_req}, 16'd0);
        checkOutput("rst_dat", fifo_wr_dat, 16'h0000);
        checkOutput("rst_busy", {15'd0, busy}, 16'd0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("idle_req", {15'd0, fifo_wr_req}, 16'd1);
        checkOutput("idle_dat", fifo_wr_dat, 16'h0000);

        // Shot: first samples, a 100-cycle stall, then resume.
        $display("[TB] shot with stall");
        applyStimulus(1, 0, 0, 0);
        checkOutput("shot_s0", fifo_wr_dat, 16'd12288);
        checkOutput("shot_busy", {15'd0, busy}, 16'd1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("shot_s1", fifo_wr_dat, 16'd12281);
        applyStimulus(0, 0, 0, 0);
        checkOutput("shot_s2", fifo_wr_dat, 16'd12274);
        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("stall_dat", fifo_wr_dat, 16'd12274);
        checkOutput("stall_req", {15'd0, fifo_wr_req}, 16'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("shot_s3", fifo_wr_dat, 16'd12267);
        applyStimulus(0, 0, 0, 0);
        checkOutput("shot_s4", fifo_wr_dat, 16'hD01C);
        for (int i = 0; i < 400; i++) applyStimulus(0, 0, ($urandom_range(0, 2) == 0), 0);
        for (int i = 0; i < 1600; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("shot_end_dat", fifo_wr_dat, 16'h0000);
        checkOutput("shot_end_busy", {15'd0, busy}, 16'd0);

        // Boom and shot together, then stray shots during the boom.
        $display("[TB] boom priority");
        applyStimulus(1, 1, 0, 0);
`ifdef SFX_BOOM_EN
        checkOutput("boom_s0", fifo_wr_dat, 16'd12288);
        applyStimulus(0, 0, 0, 0);
        checkOutput("boom_s1", fifo_wr_dat, 16'hD003);
`endif
        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom_range(0, 40) == 0), 0, ($urandom_range(0, 3) == 0), 0);
        for (int i = 0; i < 4000; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("boom_end_dat", fifo_wr_dat, 16'h0000);
        checkOutput("boom_end_busy", {15'd0, busy}, 16'd0);

        // Boom preempts a shot, restarts itself, then a reset mid-effect.
        $display("[TB] preempt and reset");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 500; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
`ifdef SFX_BOOM_EN
        checkOutput("preempt_s0", fifo_wr_dat, 16'd12288);
`endif
        for (int i = 0; i < 200; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
`ifdef SFX_BOOM_EN
        checkOutput("restart_s0", fifo_wr_dat, 16'd12288);
`endif
        for (int i = 0; i < 800; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("reset_mid_dat", fifo_wr_dat, 16'h0000);
        checkOutput("reset_mid_busy", {15'd0, busy}, 16'd0);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("lost_trig_busy", {15'd0, busy}, 16'd0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("post_rst_dat", fifo_wr_dat, 16'h0000);

        // Random mix of triggers, back-pressure and occasional resets.
        $display("[TB] random traffic");
        for (int i = 0; i < 6000; i++)
            applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 799) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2999) == 0));
        applyStimulus(0, 0, 0, 0);

        @(negedge clk50);
        #1;
        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
